dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bridge downstream of the EX/MEM/WB datapath. It accepts one load or store per cycle from the EX stage, drives a single-outstanding word-wide memory port with byte strobes, and returns sign/zero-extended load data in the MEM stage. Its `rready`/`wready` outputs feed the pipeline's dcache stall (`stall = ~(rready | wready)`), so the pipeline advances only when the pending access completes.

## Interface
- `CNT_W`, default 32: width of each performance counter (used only with `DMEM_PERF_EN`).
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rstn`, input, 1: asynchronous active-low reset.
- `rvalid`, input, 1: EX-stage load request.
- `wvalid`, input, 1: EX-stage store request.
- `addr`, input, 32: byte address.
- `mem_type`, input, 3: access type.
  - Loads: 000 LD.W, 010 LD.B, 011 LD.H, 100 LD.BU, 101 LD.HU.
  - Stores: 001 ST.W, 110 ST.B, 111 ST.H.
- `wdata`, input, 32: store data, unshifted (data in the low lanes).
- `rdata`, output, 32: extended load data for the MEM stage.
- `rready`, output, 1: no load is pending, or the pending load completes this cycle.
- `wready`, output, 1: no store is pending, or the pending store completes this cycle.
- `mem_req`, output, 1: memory request; held high until `mem_ack`.
- `mem_we`, output, 1: 1 = write.
- `mem_wstrb`, output, 4: byte-lane strobes. Value is 0000 on reads.
- `mem_addr`, output, 32: word-aligned address, `{addr[31:2], 2'b00}`.
- `mem_wdata`, output, 32: lane-shifted store data.
- `mem_rdata`, input, 32: read data; valid in the `mem_ack` cycle.
- `mem_ack`, input, 1: completion; may be high in the first cycle of `mem_req`.
- `perf_ld`, `perf_st`, `perf_stall`, outputs, `CNT_W` each: present only with `DMEM_PERF_EN`.

## Operation
- FSM states:
  - IDLE: no request pending.
  - RD: a load is pending.
  - WR: a store is pending.
- Accept condition: `acc = (state==IDLE) | mem_ack`. Evaluated every cycle.
- On a clock edge with `acc`:
  - If `wvalid`: go to WR and latch addr, type, shifted data and strobes.
  - Else if `rvalid`: go to RD and latch addr and type.
  - Else: go to IDLE.
- If `rvalid` and `wvalid` are both high, the store wins and the load is dropped.
- Requests arriving while `acc` = 0 are ignored. The pipeline is stalled then and re-presents the same request.
- In RD or WR, `mem_req` = 1 and the memory outputs come from the latched registers.
- Store lane mapping, where `a = addr[1:0]`:
  - ST.B: `wstrb = 0001 << a`, `mem_wdata = wdata << (8*a)`.
  - ST.H: `wstrb = addr[1] ? 1100 : 0011`, `mem_wdata = wdata << (16*addr[1])`.
  - ST.W: `wstrb = 1111`, `mem_wdata = wdata`.
- Load extraction from `mem_rdata`, using the latched `addr[1:0]`:
  - LD.B / LD.BU: select byte `a`, then sign- or zero-extend.
  - LD.H / LD.HU: select half `addr[1]`, then sign- or zero-extend.
  - LD.W: pass through.
- Misaligned H/W accesses are not trapped here. The low address bits beyond the lane select are ignored.
- Ready outputs:
  - `rready = (state!=RD) | mem_ack`.
  - `wready = (state!=WR) | mem_ack`.
- `rdata`:
  - In RD with `mem_ack`: the combinational extended value.
  - Otherwise: a hold register, which loads that value on each load completion.

## Timing
- Reset values:
  - state = IDLE.
  - `mem_req` = 0, `mem_we` = 0, `mem_wstrb` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `rdata` = 0.
  - `rready` = 1, `wready` = 1.
  - Counters = 0.
- Latency:
  - A request accepted at edge T gives `mem_req` high from cycle T+1.
  - With zero-wait memory (`mem_ack` in T+1), the access completes in T+1 with no stall.
  - Each additional wait cycle adds one stall cycle.
- Back-to-back: in an ack cycle, a new request is accepted at the same edge, so `mem_req` stays high continuously.
- Reset asserted mid-access: `mem_req` drops immediately (asynchronously). The pending access is abandoned and no completion is reported.
- A `mem_ack` while in IDLE is ignored.

## Configuration
- `DMEM_PERF_EN` defined:
  - `perf_ld` increments on each load completion.
  - `perf_st` increments on each store completion.
  - `perf_stall` increments each cycle that state!=IDLE and `mem_ack` = 0.
  - All counters wrap modulo 2^`CNT_W`.
- `DMEM_PERF_EN` undefined: the `perf_*` ports and counter logic are absent. All other behaviour is identical.

## Test plan
- ST.B: addr=0x1003, wdata=0x000000A5, ack in the first cycle -> next cycle `mem_addr`=0x1000, `wstrb`=1000, `mem_wdata`=0xA5000000, `wready`=1.
- LD.B: addr=0x2001, `mem_rdata`=0x1234_80FF, ack after 3 waits -> `rready` low for 3 cycles, then `rdata`=0xFFFFFF80. Same access as LD.BU -> `rdata`=0x00000080.
- LD.H: addr=0x2002 with `mem_rdata`=0x8001_0000 -> 0xFFFF8001. Same access as LD.HU -> 0x00008001.
- Back-to-back: ST.W then LD.W with an ack each cycle -> `mem_req` stays high for 2 cycles and `mem_we` goes 1 then 0.
- `rvalid` and `wvalid` both high -> a store is issued and no read occurs. Reset pulsed during a 5-cycle wait -> `mem_req`=0 immediately, and `rready`/`wready`=1 after reset.
- With `DMEM_PERF_EN`: 2 loads (1 wait each) plus 1 store -> `perf_ld`=2, `perf_st`=1, `perf_stall`=2.

Source files
------------

// File: rtl/dmem_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bridge
//
// Data-memory bridge between the EX/MEM/WB pipeline and a word-wide memory
// port. Accepts one load or store per cycle and keeps at most one access
// outstanding. Store data is shifted into byte lanes with matching strobes.
// Load data is extracted from the returned word and sign- or zero-extended.
//
// Optional feature macro: DMEM_PERF_EN adds load/store/stall counters.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   rvalid, wvalid       EX-stage load / store request
//   addr, mem_type       byte address and access type
//   wdata                store data, unshifted
//   rdata                extended load data for the MEM stage
//   rready, wready       no load/store pending, or it completes this cycle
//   mem_req, mem_we      memory request (held until mem_ack), write enable
//   mem_wstrb            byte-lane strobes (0000 on reads)
//   mem_addr, mem_wdata  word-aligned address, lane-shifted store data
//   mem_rdata, mem_ack   read data and completion from memory
//   perf_ld/st/stall     performance counters (DMEM_PERF_EN only)
// ---------------------------------------------------------------------------
module dmem_bridge #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rvalid,
    input  logic        wvalid,
    input  logic [31:0] addr,
    input  logic [2:0]  mem_type,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rready,
    output logic        wready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DMEM_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_ld,
    output logic [CNT_W-1:0] perf_st,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_e;

    localparam logic [2:0] T_LD_W  = 3'b000;
    localparam logic [2:0] T_LD_B  = 3'b010;
    localparam logic [2:0] T_LD_H  = 3'b011;
    localparam logic [2:0] T_LD_BU = 3'b100;
    localparam logic [2:0] T_LD_HU = 3'b101;
    localparam logic [2:0] T_ST_B  = 3'b110;
    localparam logic [2:0] T_ST_H  = 3'b111;

    state_e      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [2:0]  type_q,  type_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q,  strb_d;
    logic [31:0] rdata_q, rdata_d;

    logic        acc;
    logic        ld_done;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Store lane placement from the live request (latched on accept).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        st_strb = 4'b1111;
        st_data = wdata;
        case (mem_type)
            T_ST_B: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = wdata << {addr[1:0], 3'b000};
            end
            T_ST_H: begin
                st_strb = addr[1] ? 4'b1100 : 4'b0011;
                st_data = wdata << {addr[1], 4'b0000};
            end
            default: ;
        endcase
    end

    // Load extraction uses the latched address/type, since mem_rdata
    // arrives cycles after the request left the EX stage.
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            2'd3:    ld_byte = mem_rdata[31:24];
            default: ;
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (type_q)
            T_LD_B:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            T_LD_BU: ld_ext = {24'd0, ld_byte};
            T_LD_H:  ld_ext = {{16{ld_half[15]}}, ld_half};
            T_LD_HU: ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    assign acc     = (state_q == S_IDLE) | mem_ack;
    assign ld_done = (state_q == S_RD) & mem_ack;

    // Next-state logic: a new request is taken whenever the port is free
    // or the current access completes this cycle; the store wins a tie.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = ld_done ? ld_ext : rdata_q;
        if (acc) begin
            if (wvalid) begin
                state_d = S_WR;
                addr_d  = addr;
                type_d  = mem_type;
                wdata_d = st_data;
                strb_d  = st_strb;
            end else if (rvalid) begin
                state_d = S_RD;
                addr_d  = addr;
                type_d  = mem_type;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            type_q  <= T_LD_W;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_req   = (state_q != S_IDLE);
    assign mem_we    = (state_q == S_WR);
    assign mem_wstrb = (state_q == S_WR) ? strb_q : 4'b0000;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign rready    = (state_q != S_RD) | mem_ack;
    assign wready    = (state_q != S_WR) | mem_ack;
    assign rdata     = ld_done ? ld_ext : rdata_q;

`ifdef DMEM_PERF_EN
    logic             st_done;
    logic             stalled;
    logic [CNT_W-1:0] perf_ld_q, perf_st_q, perf_stall_q;

    assign st_done = (state_q == S_WR) & mem_ack;
    assign stalled = (state_q != S_IDLE) & ~mem_ack;

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_ld_q    <= '0;
            perf_st_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (ld_done) perf_ld_q    <= perf_ld_q + 1'b1;
            if (st_done) perf_st_q    <= perf_st_q + 1'b1;
            if (stalled) perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign perf_ld    = perf_ld_q;
    assign perf_st    = perf_st_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_bridge
//
// Self-checking bench for dmem_bridge. A transaction-level model (one pending
// access plus the load hold value) predicts every output; lane placement and
// extension are computed arithmetically. Directed sequences pin the literal
// cases, then a randomized pipeline/memory pair exercises the rest.
// ---------------------------------------------------------------------------
module tb_dmem_bridge;

    logic        clk;
    logic        rstn;
    logic        rvalid, wvalid;
    logic [31:0] addr;
    logic [2:0]  mem_type;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rready, wready;
    logic        mem_req, mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef DMEM_PERF_EN
    logic [31:0] perf_ld, perf_st, perf_stall;
`endif

    dmem_bridge #(.CNT_W(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rvalid    (rvalid),
        .wvalid    (wvalid),
        .addr      (addr),
        .mem_type  (mem_type),
        .wdata     (wdata),
        .rdata     (rdata),
        .rready    (rready),
        .wready    (wready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DMEM_PERF_EN
        ,
        .perf_ld   (perf_ld),
        .perf_st   (perf_st),
        .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // ---- behavioural reference -------------------------------------------
    function automatic logic [31:0] ld_model(input logic [2:0] t, input logic [31:0] a,
                                             input logic [31:0] d);
        int          sz;
        int          lane;
        bit          sgn;
        logic [31:0] v;
        logic [31:0] mask;
        sgn = (t == 3'b010) || (t == 3'b011);
        if (t == 3'b010 || t == 3'b100)      sz = 1;
        else if (t == 3'b011 || t == 3'b101) sz = 2;
        else                                 sz = 4;
        lane = (int'(a[1:0]) / sz) * sz;
        v = d >> (8 * lane);
        if (sz < 4) begin
            mask = (32'd1 << (8 * sz)) - 32'd1;
            v = v & mask;
            if (sgn && v[8*sz-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic st_model(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                            output logic [3:0] strb, output logic [31:0] data);
        int          sz;
        int          lane;
        logic [31:0] s;
        sz   = (t == 3'b110) ? 1 : (t == 3'b111) ? 2 : 4;
        lane = (int'(a[1:0]) / sz) * sz;
        s    = ((32'd1 << sz) - 32'd1) << lane;
        strb = s[3:0];
        data = wd << (8 * lane);
    endtask

    // Pending access and load-hold value, updated at each clock edge.
    logic        m_pv, m_wr;
    logic [31:0] m_addr, m_wdata, m_hold;
    logic [2:0]  m_type;
    logic [31:0] m_ld, m_st, m_stall;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pv <= 1'b0; m_wr <= 1'b0; m_addr <= '0; m_type <= '0;
            m_wdata <= '0; m_hold <= '0; m_ld <= '0; m_st <= '0; m_stall <= '0;
        end else begin
            if (m_pv && mem_ack) begin
                if (m_wr) m_st <= m_st + 1;
                else begin
                    m_ld   <= m_ld + 1;
                    m_hold <= ld_model(m_type, m_addr, mem_rdata);
                end
            end
            if (m_pv && !mem_ack) m_stall <= m_stall + 1;
            if (!m_pv || mem_ack) begin
                if (wvalid || rvalid) begin
                    m_pv <= 1'b1; m_wr <= wvalid; m_addr <= addr;
                    m_type <= mem_type; m_wdata <= wdata;
                end else begin
                    m_pv <= 1'b0;
                end
            end
        end
    end

    // ---- per-cycle compare against the model ------------------------------
    logic        chk_on = 1'b0;
    logic [3:0]  c_strb;
    logic [31:0] c_data;
    logic        c_ldack;

    always @(negedge clk) begin
        #2;
        if (rstn && chk_on) begin
            c_ldack = m_pv && !m_wr && mem_ack;
            check("mem_req", {31'd0, mem_req}, {31'd0, m_pv});
            check("rready", {31'd0, rready}, {31'd0, !(m_pv && !m_wr) || mem_ack});
            check("wready", {31'd0, wready}, {31'd0, !(m_pv && m_wr) || mem_ack});
            check("rdata", rdata, c_ldack ? ld_model(m_type, m_addr, mem_rdata) : m_hold);
            if (m_pv) begin
                check("mem_we", {31'd0, mem_we}, {31'd0, m_wr});
                check("mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
                if (m_wr) begin
                    st_model(m_type, m_addr, m_wdata, c_strb, c_data);
                    check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, c_strb});
                    check("mem_wdata", mem_wdata, c_data);
                end else begin
                    check("mem_wstrb_rd", {28'd0, mem_wstrb}, 32'd0);
                end
            end
`ifdef DMEM_PERF_EN
            check("perf_ld", perf_ld, m_ld);
            check("perf_st", perf_st, m_st);
            check("perf_stall", perf_stall, m_stall);
`endif
        end
    end

    // ---- stimulus ---------------------------------------------------------
    task automatic step(input logic rv, input logic wv, input logic [31:0] a,
                        input logic [2:0] t, input logic [31:0] wd,
                        input logic ack, input logic [31:0] rd);
        @(negedge clk);
        rvalid = rv; wvalid = wv; addr = a; mem_type = t; wdata = wd;
        mem_ack = ack; mem_rdata = rd;
        #3;
    endtask

    task automatic idle(input logic ack, input logic [31:0] rd);
        step(1'b0, 1'b0, 32'd0, 3'd0, 32'd0, ack, rd);
    endtask

    logic [2:0]  ld_types [5] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101};
    logic [2:0]  st_types [3] = '{3'b001, 3'b110, 3'b111};
    logic [3:0]  p_strb;
    logic [31:0] p_data;
    logic        have_req, q_rv, q_wv, r_ack;
    logic [31:0] q_a, q_wd;
    logic [2:0]  q_t;
    int          k;

    initial begin
        rstn = 1'b0;
        rvalid = 0; wvalid = 0; addr = 0; mem_type = 0; wdata = 0;
        mem_ack = 0; mem_rdata = 0;

        // Model pins.
        check("model_ldb", ld_model(3'b010, 32'h2001, 32'h1234_80FF), 32'hFFFF_FF80);
        check("model_ldbu", ld_model(3'b100, 32'h2001, 32'h1234_80FF), 32'h0000_0080);
        check("model_ldh", ld_model(3'b011, 32'h2002, 32'h8001_0000), 32'hFFFF_8001);
        st_model(3'b110, 32'h1003, 32'hA5, p_strb, p_data);
        check("model_stb_strb", {28'd0, p_strb}, 32'h8);
        check("model_stb_data", p_data, 32'hA500_0000);
        st_model(3'b111, 32'h0002, 32'h1234, p_strb, p_data);
        check("model_sth_data", p_data, 32'h1234_0000);

        // Reset values.
        #12;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd1);
        check("rst_wready", {31'd0, wready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        chk_on = 1'b1;

        // Ack while idle is ignored.
        idle(1'b1, 32'hFFFF_FFFF);
        idle(1'b0, 32'd0);
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);
        check("idle_ack_rdata", rdata, 32'd0);

        // ST.B, zero-wait.
        step(1'b0, 1'b1, 32'h1003, 3'b110, 32'h0000_00A5, 1'b0, 32'd0);
        idle(1'b1, 32'd0);
        check("stb_addr", mem_addr, 32'h1000);
        check("stb_strb", {28'd0, mem_wstrb}, 32'h8);
        check("stb_wdata", mem_wdata, 32'hA500_0000);
        check("stb_wready", {31'd0, wready}, 32'd1);
        idle(1'b0, 32'd0);

        // LD.B with 3 waits, then LD.BU zero-wait.
        step(1'b1, 1'b0, 32'h2001, 3'b010, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 32'd0);
            check("ldb_wait_rready", {31'd0, rready}, 32'd0);
        end
        idle(1'b1, 32'h1234_80FF);
        check("ldb_rready", {31'd0, rready}, 32'd1);
        check("ldb_rdata", rdata, 32'hFFFF_FF80);
        idle(1'b0, 32'd0);
        check("ldb_hold", rdata, 32'hFFFF_FF80);
        step(1'b1, 1'b0, 32'h2001, 3'b100, 32'd0, 1'b0, 32'd0);
        idle(1'b1, 32'h1234_80FF);
        check("ldbu_rdata", rdata, 32'h0000_0080);

        // LD.H / LD.HU upper half.
        step(1'b1, 1'b0, 32'h2002, 3'b011, 32'd0, 1'b0, 32'd0);
        idle(1'b1, 32'h8001_0000);
        check("ldh_rdata", rdata, 32'hFFFF_8001);
        step(1'b1, 1'b0, 32'h2002, 3'b101, 32'd0, 1'b0, 32'd0);
        idle(1'b1, 32'h8001_0000);
        check("ldhu_rdata", rdata, 32'h0000_8001);

        // Back-to-back ST.W then LD.W.
        step(1'b0, 1'b1, 32'h3000, 3'b001, 32'hDEAD_BEEF, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'h3004, 3'b000, 32'd0, 1'b1, 32'd0);
        check("b2b_req1", {31'd0, mem_req}, 32'd1);
        check("b2b_we1", {31'd0, mem_we}, 32'd1);
        idle(1'b1, 32'hCAFE_F00D);
        check("b2b_req2", {31'd0, mem_req}, 32'd1);
        check("b2b_we2", {31'd0, mem_we}, 32'd0);
        check("b2b_addr2", mem_addr, 32'h3004);
        check("b2b_rdata", rdata, 32'hCAFE_F00D);
        idle(1'b0, 32'd0);
        check("b2b_req_end", {31'd0, mem_req}, 32'd0);

        // Both valid: store wins, no read follows.
        step(1'b1, 1'b1, 32'h4000, 3'b001, 32'h11, 1'b0, 32'd0);
        idle(1'b0, 32'd0);
        check("both_we", {31'd0, mem_we}, 32'd1);
        check("both_strb", {28'd0, mem_wstrb}, 32'hF);
        idle(1'b1, 32'd0);
        idle(1'b0, 32'd0);
        check("both_no_read", {31'd0, mem_req}, 32'd0);

        // Reset during a long wait.
        step(1'b1, 1'b0, 32'h5000, 3'b000, 32'd0, 1'b0, 32'd0);
        idle(1'b0, 32'd0);
        idle(1'b0, 32'd0);
        check("rstmid_req_before", {31'd0, mem_req}, 32'd1);
        rstn = 1'b0;
        #1;
        check("rstmid_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #3;
        check("rstmid_rready", {31'd0, rready}, 32'd1);
        check("rstmid_wready", {31'd0, wready}, 32'd1);
        check("rstmid_rdata", rdata, 32'd0);

        // Two loads with one wait each, one zero-wait store.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'h10, 3'b000, 32'd0, 1'b0, 32'd0);
            idle(1'b0, 32'd0);
            idle(1'b1, 32'h55);
        end
        step(1'b0, 1'b1, 32'h20, 3'b001, 32'h77, 1'b0, 32'd0);
        idle(1'b1, 32'd0);
        idle(1'b0, 32'd0);
`ifdef DMEM_PERF_EN
        check("perf_ld_lit", perf_ld, 32'd2);
        check("perf_st_lit", perf_st, 32'd1);
        check("perf_stall_lit", perf_stall, 32'd2);
`endif

        // Randomized pipeline + memory; a request is re-presented until taken.
        have_req = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!have_req) begin
                k    = int'($urandom_range(0, 9));
                q_rv = (k <= 3) || (k == 7);
                q_wv = (k >= 4) && (k <= 7);
                q_a  = $urandom;
                q_wd = $urandom;
                q_t  = q_wv ? st_types[$urandom_range(0, 2)] : ld_types[$urandom_range(0, 4)];
                have_req = 1'b1;
            end
            @(negedge clk);
            if (m_pv) r_ack = ($urandom_range(0, 2) != 0);
            else      r_ack = ($urandom_range(0, 7) == 0);
            rvalid = q_rv; wvalid = q_wv; addr = q_a; mem_type = q_t; wdata = q_wd;
            mem_ack = r_ack; mem_rdata = $urandom;
            if (!m_pv || r_ack) have_req = 1'b0;
            #3;
        end
        idle(1'b1, 32'd0);
        idle(1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
